id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register for the 5-stage RV32I core, sitting directly upstream of the ALU operand select stage. It captures decoded operands and control from ID. It computes registered forwarding codes (`forward1`/`forward2`) for the operand select. It detects load-use hazards and inserts bubbles, and it applies branch flushes and global pipeline holds.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `REGW`, 5, register address width

Ports:
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low; all state clears while low
- `io_hold` in 1: global pipeline freeze (memory stall)
- `io_flush` in 1: branch/jump taken in EX; kill the instruction entering EX
- `io_id_valid` in 1: ID holds a real instruction
- `io_id_rs1_addr`, `io_id_rs2_addr`, `io_id_rd_addr` in REGW: register addresses
- `io_id_rs1_data`, `io_id_rs2_data`, `io_id_imm` in XLEN: operands and immediate
- `io_id_immsrc`, `io_id_islui`, `io_id_memread`, `io_id_memwrite`, `io_id_regwrite` in 1: control bits
- `io_id_aluop` in 4: ALU operation
- `io_exmem_rd_addr` in REGW, `io_exmem_regwrite` in 1: destination of the instruction now in MEM
- `io_stall` out 1: combinational load-use stall; holds PC and IF/ID
- `io_ex_*` out: registered copies of every `io_id_*` field, same widths
- `io_ex_forward1`, `io_ex_forward2` out 2: registered forward codes
- `io_stall_count` out 32: saturating count of inserted load-use bubbles

## Operation
- Forward codes (package constants): `FWD_RF`=0 (use the register-file value), `FWD_MEM`=1 (use the MEM-stage ALU result), `FWD_WB`=2 (use the writeback data). Code 3 is never produced.
- Forward codes are computed in ID for each source n ∈ {1,2}, then registered:
  - `FWD_MEM` if `ex_valid & ex_regwrite & ex_rd != 0 & ex_rd == rsn`. The instruction now in EX will be in MEM next cycle.
  - else `FWD_WB` if `io_exmem_regwrite & io_exmem_rd_addr != 0 & io_exmem_rd_addr == rsn`.
  - else `FWD_RF`.
  - The younger (EX) producer has priority. rd=x0 never forwards. WB→ID same-cycle is handled by the register file bypass, not here.
- Load-use: `io_stall = io_id_valid & ex_valid & ex_memread & ex_rd != 0 & (ex_rd == rs1 | ex_rd == rs2)`.
  - Deasserted while `io_flush` is high; deasserted while `io_hold` is high.
- Register update priority each edge:
  1. `io_hold`: all state unchanged, including the counter.
  2. else `io_flush`: load bubble.
  3. else `io_stall`: load bubble, and `io_stall_count` += 1, saturating at 0xFFFFFFFF.
  4. else: load all ID fields and the computed forward codes.
- Bubble definition: valid, regwrite, memread, memwrite, immsrc, islui = 0; rd/rs addresses = 0; data fields = 0; aluop = 0; forward codes = `FWD_RF`.

## Timing
- Reset value: every `io_ex_*` output is 0, forward codes are `FWD_RF`, and `io_stall_count` is 0. This is a bubble.
- Latency: ID fields appear on `io_ex_*` one cycle after capture.
- `io_stall` is combinational within the same cycle and never depends on `io_ex_*` outputs of the same edge.
- A load followed immediately by a dependent instruction produces exactly one bubble. The dependent instruction then enters EX with `FWD_WB` on the matching source.
- Flush and stall in the same cycle: flush wins, stall output is 0, and the counter does not increment.
- Hold plus flush: hold wins; the EX instruction is frozen and re-asserts flush on release.
- Reset asserted mid-operation clears the register immediately (asynchronously). The first edge after release loads normally.

## Structure
- Shared package `core_pkg`: `FWD_RF`/`FWD_MEM`/`FWD_WB` constants, ALU op encodings, bubble field values.
- Sub-module `hazard_forward_unit`: purely combinational; produces the forward codes and `io_stall` from ID addresses, EX-stage state and MEM-stage inputs.
- Pipeline register, bubble muxing and counter live in `id_ex_stage`.

## Test plan
- Reset low with random inputs: all outputs zero and codes 0. After release, ADD x3,x1,x2 with rs1_data=5, rs2_data=7 appears next cycle with forward codes 0/0.
- ADD x5,… then SUB x6,x5,x5 back-to-back: SUB enters EX with forward1=1, forward2=1. With one unrelated instruction between them: codes 2/2.
- LW x4 then ADD x7,x4,x1: `io_stall`=1 for one cycle, bubble in EX, `io_stall_count`=1, then ADD with forward1=2, forward2=0.
- Producer rd=x0 followed by a consumer reading x0: codes stay 0 and no stall, including when the producer is a load.
- Load-use hazard with `io_flush`=1 in the same cycle: stall=0, bubble loaded, counter unchanged. Same hazard with `io_hold`=1: all `io_ex_*` outputs unchanged for 3 hold cycles.
- Preload the counter near 0xFFFFFFFF via repeated load-use: it stays at 0xFFFFFFFF after a further stall.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: forwarding codes, ALU op encodings and the bubble value.
package core_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [3:0] BUBBLE_ALUOP = ALU_ADD;

  // The younger EX producer wins over the MEM producer.
  function automatic logic [1:0] fwd_code(input logic ex_hit, input logic mem_hit);
    if (ex_hit)       return FWD_MEM;
    else if (mem_hit) return FWD_WB;
    else              return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_forward_unit.sv
// Combinational forward-code selection and load-use stall detection for the
// instruction in ID against the EX and MEM producers.
module hazard_forward_unit
  import core_pkg::*;
#(
  parameter int REGW = 5
) (
  input  logic            id_valid_i,
  input  logic [REGW-1:0] rs1_i,
  input  logic [REGW-1:0] rs2_i,
  input  logic            ex_valid_i,
  input  logic            ex_regwrite_i,
  input  logic            ex_memread_i,
  input  logic [REGW-1:0] ex_rd_i,
  input  logic            mem_regwrite_i,
  input  logic [REGW-1:0] mem_rd_i,
  input  logic            hold_i,
  input  logic            flush_i,
  output logic [1:0]      fwd1_o,
  output logic [1:0]      fwd2_o,
  output logic            stall_o
);

  logic ex_wr, mem_wr;
  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;

  assign ex_wr    = ex_valid_i & ex_regwrite_i & (ex_rd_i != '0);
  assign mem_wr   = mem_regwrite_i & (mem_rd_i != '0);
  assign ex_hit1  = ex_wr & (ex_rd_i == rs1_i);
  assign ex_hit2  = ex_wr & (ex_rd_i == rs2_i);
  assign mem_hit1 = mem_wr & (mem_rd_i == rs1_i);
  assign mem_hit2 = mem_wr & (mem_rd_i == rs2_i);

  assign fwd1_o = fwd_code(ex_hit1, mem_hit1);
  assign fwd2_o = fwd_code(ex_hit2, mem_hit2);

  assign stall_o = id_valid_i & ex_valid_i & ex_memread_i & (ex_rd_i != '0) &
                   ((ex_rd_i == rs1_i) | (ex_rd_i == rs2_i)) & ~flush_i & ~hold_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with registered forward codes, load-use bubble
// insertion, flush/hold handling and a saturating bubble counter.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_hold,
  input  logic            io_flush,
  input  logic            io_id_valid,
  input  logic [REGW-1:0] io_id_rs1_addr,
  input  logic [REGW-1:0] io_id_rs2_addr,
  input  logic [REGW-1:0] io_id_rd_addr,
  input  logic [XLEN-1:0] io_id_rs1_data,
  input  logic [XLEN-1:0] io_id_rs2_data,
  input  logic [XLEN-1:0] io_id_imm,
  input  logic            io_id_immsrc,
  input  logic            io_id_islui,
  input  logic            io_id_memread,
  input  logic            io_id_memwrite,
  input  logic            io_id_regwrite,
  input  logic [3:0]      io_id_aluop,
  input  logic [REGW-1:0] io_exmem_rd_addr,
  input  logic            io_exmem_regwrite,
  output logic            io_stall,
  output logic            io_ex_valid,
  output logic [REGW-1:0] io_ex_rs1_addr,
  output logic [REGW-1:0] io_ex_rs2_addr,
  output logic [REGW-1:0] io_ex_rd_addr,
  output logic [XLEN-1:0] io_ex_rs1_data,
  output logic [XLEN-1:0] io_ex_rs2_data,
  output logic [XLEN-1:0] io_ex_imm,
  output logic            io_ex_immsrc,
  output logic            io_ex_islui,
  output logic            io_ex_memread,
  output logic            io_ex_memwrite,
  output logic            io_ex_regwrite,
  output logic [3:0]      io_ex_aluop,
  output logic [1:0]      io_ex_forward1,
  output logic [1:0]      io_ex_forward2,
  output logic [31:0]     io_stall_count
);

  typedef struct packed {
    logic            valid;
    logic [REGW-1:0] rs1_addr;
    logic [REGW-1:0] rs2_addr;
    logic [REGW-1:0] rd_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            immsrc;
    logic            islui;
    logic            memread;
    logic            memwrite;
    logic            regwrite;
    logic [3:0]      aluop;
    logic [1:0]      fwd1;
    logic [1:0]      fwd2;
  } ex_fields_t;

  // All-zero matches the bubble: FWD_RF and BUBBLE_ALUOP are both zero.
  localparam ex_fields_t BUBBLE = '0;

  ex_fields_t ex_q, ex_d, id_fields;
  logic [31:0] stall_count_q, stall_count_d;
  logic [1:0]  fwd1, fwd2;

  hazard_forward_unit #(.REGW(REGW)) u_hfu (
    .id_valid_i     (io_id_valid),
    .rs1_i          (io_id_rs1_addr),
    .rs2_i          (io_id_rs2_addr),
    .ex_valid_i     (ex_q.valid),
    .ex_regwrite_i  (ex_q.regwrite),
    .ex_memread_i   (ex_q.memread),
    .ex_rd_i        (ex_q.rd_addr),
    .mem_regwrite_i (io_exmem_regwrite),
    .mem_rd_i       (io_exmem_rd_addr),
    .hold_i         (io_hold),
    .flush_i        (io_flush),
    .fwd1_o         (fwd1),
    .fwd2_o         (fwd2),
    .stall_o        (io_stall)
  );

  assign id_fields = '{
    valid:    io_id_valid,
    rs1_addr: io_id_rs1_addr,
    rs2_addr: io_id_rs2_addr,
    rd_addr:  io_id_rd_addr,
    rs1_data: io_id_rs1_data,
    rs2_data: io_id_rs2_data,
    imm:      io_id_imm,
    immsrc:   io_id_immsrc,
    islui:    io_id_islui,
    memread:  io_id_memread,
    memwrite: io_id_memwrite,
    regwrite: io_id_regwrite,
    aluop:    io_id_aluop,
    fwd1:     fwd1,
    fwd2:     fwd2
  };

  always_comb begin
    ex_d          = ex_q;
    stall_count_d = stall_count_q;
    if (io_hold) begin
      ex_d = ex_q;
    end else if (io_flush) begin
      ex_d = BUBBLE;
    end else if (io_stall) begin
      ex_d = BUBBLE;
      if (stall_count_q != 32'hFFFF_FFFF) stall_count_d = stall_count_q + 32'd1;
    end else begin
      ex_d = id_fields;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_q          <= BUBBLE;
      stall_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign io_ex_valid    = ex_q.valid;
  assign io_ex_rs1_addr = ex_q.rs1_addr;
  assign io_ex_rs2_addr = ex_q.rs2_addr;
  assign io_ex_rd_addr  = ex_q.rd_addr;
  assign io_ex_rs1_data = ex_q.rs1_data;
  assign io_ex_rs2_data = ex_q.rs2_data;
  assign io_ex_imm      = ex_q.imm;
  assign io_ex_immsrc   = ex_q.immsrc;
  assign io_ex_islui    = ex_q.islui;
  assign io_ex_memread  = ex_q.memread;
  assign io_ex_memwrite = ex_q.memwrite;
  assign io_ex_regwrite = ex_q.regwrite;
  assign io_ex_aluop    = ex_q.aluop;
  assign io_ex_forward1 = ex_q.fwd1;
  assign io_ex_forward2 = ex_q.fwd2;
  assign io_stall_count = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding, load-use, flush/hold,
// asynchronous reset and counter saturation.
module tb_id_ex_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_hold, io_flush, io_id_valid;
  logic [4:0]  io_id_rs1_addr, io_id_rs2_addr, io_id_rd_addr;
  logic [31:0] io_id_rs1_data, io_id_rs2_data, io_id_imm;
  logic        io_id_immsrc, io_id_islui, io_id_memread, io_id_memwrite, io_id_regwrite;
  logic [3:0]  io_id_aluop;
  logic [4:0]  io_exmem_rd_addr;
  logic        io_exmem_regwrite;
  logic        io_stall;
  logic        io_ex_valid;
  logic [4:0]  io_ex_rs1_addr, io_ex_rs2_addr, io_ex_rd_addr;
  logic [31:0] io_ex_rs1_data, io_ex_rs2_data, io_ex_imm;
  logic        io_ex_immsrc, io_ex_islui, io_ex_memread, io_ex_memwrite, io_ex_regwrite;
  logic [3:0]  io_ex_aluop;
  logic [1:0]  io_ex_forward1, io_ex_forward2;
  logic [31:0] io_stall_count;

  int tests = 0;
  int fails = 0;

  id_ex_stage #(.XLEN(32), .REGW(5)) dut (
    .clock(clock), .reset(reset), .io_hold(io_hold), .io_flush(io_flush),
    .io_id_valid(io_id_valid), .io_id_rs1_addr(io_id_rs1_addr),
    .io_id_rs2_addr(io_id_rs2_addr), .io_id_rd_addr(io_id_rd_addr),
    .io_id_rs1_data(io_id_rs1_data), .io_id_rs2_data(io_id_rs2_data),
    .io_id_imm(io_id_imm), .io_id_immsrc(io_id_immsrc), .io_id_islui(io_id_islui),
    .io_id_memread(io_id_memread), .io_id_memwrite(io_id_memwrite),
    .io_id_regwrite(io_id_regwrite), .io_id_aluop(io_id_aluop),
    .io_exmem_rd_addr(io_exmem_rd_addr), .io_exmem_regwrite(io_exmem_regwrite),
    .io_stall(io_stall), .io_ex_valid(io_ex_valid),
    .io_ex_rs1_addr(io_ex_rs1_addr), .io_ex_rs2_addr(io_ex_rs2_addr),
    .io_ex_rd_addr(io_ex_rd_addr), .io_ex_rs1_data(io_ex_rs1_data),
    .io_ex_rs2_data(io_ex_rs2_data), .io_ex_imm(io_ex_imm),
    .io_ex_immsrc(io_ex_immsrc), .io_ex_islui(io_ex_islui),
    .io_ex_memread(io_ex_memread), .io_ex_memwrite(io_ex_memwrite),
    .io_ex_regwrite(io_ex_regwrite), .io_ex_aluop(io_ex_aluop),
    .io_ex_forward1(io_ex_forward1), .io_ex_forward2(io_ex_forward2),
    .io_stall_count(io_stall_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive an ID instruction; other control bits default to zero.
  task automatic instr(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                       input logic mr, input logic rw, input logic [3:0] op);
    io_id_valid    = v;
    io_id_rs1_addr = rs1;
    io_id_rs2_addr = rs2;
    io_id_rd_addr  = rd;
    io_id_rs1_data = d1;
    io_id_rs2_data = d2;
    io_id_imm      = 32'h0;
    io_id_immsrc   = 1'b0;
    io_id_islui    = 1'b0;
    io_id_memread  = mr;
    io_id_memwrite = 1'b0;
    io_id_regwrite = rw;
    io_id_aluop    = op;
  endtask

  task automatic mem(input logic [4:0] rd, input logic rw);
    io_exmem_rd_addr  = rd;
    io_exmem_regwrite = rw;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset with random inputs
    reset = 1'b0;
    io_hold = 1'b0;
    io_flush = 1'b0;
    instr(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom,
          1'($urandom), 1'($urandom), 4'($urandom));
    io_id_imm = $urandom;
    io_id_immsrc = 1'b1;
    io_id_islui = 1'b1;
    io_id_memwrite = 1'b1;
    mem(5'($urandom), 1'b1);
    tick(); tick();
    chk("rst_valid", 32'(io_ex_valid), 32'd0);
    chk("rst_rd", 32'(io_ex_rd_addr), 32'd0);
    chk("rst_rs1_data", io_ex_rs1_data, 32'd0);
    chk("rst_imm", io_ex_imm, 32'd0);
    chk("rst_ctrl", {27'd0, io_ex_immsrc, io_ex_islui, io_ex_memread, io_ex_memwrite, io_ex_regwrite}, 32'd0);
    chk("rst_fwd", {28'd0, io_ex_forward1, io_ex_forward2}, 32'd0);
    chk("rst_cnt", io_stall_count, 32'd0);
    chk("rst_stall", 32'(io_stall), 32'd0);

    // ADD x3,x1,x2
    reset = 1'b1;
    mem(5'd0, 1'b0);
    instr(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 1'b0, 1'b1, 4'd0);
    tick();
    chk("add_valid", 32'(io_ex_valid), 32'd1);
    chk("add_rd", 32'(io_ex_rd_addr), 32'd3);
    chk("add_d1", io_ex_rs1_data, 32'd5);
    chk("add_d2", io_ex_rs2_data, 32'd7);
    chk("add_fwd", {28'd0, io_ex_forward1, io_ex_forward2}, 32'h0);

    // ADD x5 then SUB x6,x5,x5; MEM also targets x5 so EX priority is visible
    instr(1'b1, 5'd1, 5'd2, 5'd5, 32'd1, 32'd2, 1'b0, 1'b1, 4'd0);
    tick();
    instr(1'b1, 5'd5, 5'd5, 5'd6, 32'd0, 32'd0, 1'b0, 1'b1, 4'd1);
    mem(5'd5, 1'b1);
    #1;
    chk("b2b_stall", 32'(io_stall), 32'd0);
    tick();
    chk("b2b_fwd1", 32'(io_ex_forward1), 32'd1);
    chk("b2b_fwd2", 32'(io_ex_forward2), 32'd1);
    chk("b2b_aluop", 32'(io_ex_aluop), 32'd1);

    // ADD x5, unrelated ADD x9, SUB x6,x5,x5 with x5 now in MEM
    mem(5'd0, 1'b0);
    instr(1'b1, 5'd1, 5'd2, 5'd5, 32'd1, 32'd2, 1'b0, 1'b1, 4'd0);
    tick();
    instr(1'b1, 5'd1, 5'd2, 5'd9, 32'd1, 32'd2, 1'b0, 1'b1, 4'd0);
    mem(5'd6, 1'b1);
    tick();
    instr(1'b1, 5'd5, 5'd5, 5'd6, 32'd0, 32'd0, 1'b0, 1'b1, 4'd1);
    mem(5'd5, 1'b1);
    tick();
    chk("gap_fwd", {28'd0, io_ex_forward1, io_ex_forward2}, {28'd0, 2'd2, 2'd2});

    // LW x4 then ADD x7,x4,x1
    mem(5'd0, 1'b0);
    instr(1'b1, 5'd2, 5'd0, 5'd4, 32'd0, 32'd0, 1'b1, 1'b1, 4'd0);
    tick();
    instr(1'b1, 5'd4, 5'd1, 5'd7, 32'd0, 32'd3, 1'b0, 1'b1, 4'd0);
    mem(5'd6, 1'b1);
    #1;
    chk("lu_stall", 32'(io_stall), 32'd1);
    tick();
    chk("lu_bubble_valid", 32'(io_ex_valid), 32'd0);
    chk("lu_bubble_rd", 32'(io_ex_rd_addr), 32'd0);
    chk("lu_cnt", io_stall_count, 32'd1);
    mem(5'd4, 1'b1);
    #1;
    chk("lu_stall_gone", 32'(io_stall), 32'd0);
    tick();
    chk("lu_rd", 32'(io_ex_rd_addr), 32'd7);
    chk("lu_fwd", {28'd0, io_ex_forward1, io_ex_forward2}, {28'd0, 2'd2, 2'd0});
    chk("lu_cnt2", io_stall_count, 32'd1);

    // Load to x0 followed by x0 consumer; MEM also writing x0
    mem(5'd0, 1'b1);
    instr(1'b1, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, 4'd0);
    tick();
    instr(1'b1, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 1'b0, 1'b1, 4'd0);
    #1;
    chk("x0_stall", 32'(io_stall), 32'd0);
    tick();
    chk("x0_fwd", {28'd0, io_ex_forward1, io_ex_forward2}, 32'd0);
    chk("x0_valid", 32'(io_ex_valid), 32'd1);

    // Load-use with flush in the same cycle
    mem(5'd0, 1'b0);
    instr(1'b1, 5'd2, 5'd0, 5'd4, 32'd0, 32'd0, 1'b1, 1'b1, 4'd0);
    tick();
    instr(1'b1, 5'd4, 5'd1, 5'd7, 32'd0, 32'd0, 1'b0, 1'b1, 4'd0);
    io_flush = 1'b1;
    #1;
    chk("fl_stall", 32'(io_stall), 32'd0);
    tick();
    io_flush = 1'b0;
    chk("fl_valid", 32'(io_ex_valid), 32'd0);
    chk("fl_cnt", io_stall_count, 32'd1);

    // Load-use with hold for 3 cycles
    instr(1'b1, 5'd2, 5'd0, 5'd4, 32'hAB, 32'd0, 1'b1, 1'b1, 4'd0);
    tick();
    instr(1'b1, 5'd4, 5'd1, 5'd7, 32'd0, 32'd0, 1'b0, 1'b1, 4'd0);
    io_hold = 1'b1;
    io_flush = 1'b1;
    #1;
    chk("hold_stall", 32'(io_stall), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid", 32'(io_ex_valid), 32'd1);
      chk("hold_rd", 32'(io_ex_rd_addr), 32'd4);
      chk("hold_memread", 32'(io_ex_memread), 32'd1);
      chk("hold_d1", io_ex_rs1_data, 32'hAB);
      chk("hold_cnt", io_stall_count, 32'd1);
    end
    io_hold = 1'b0;
    io_flush = 1'b0;
    #1;
    chk("unhold_stall", 32'(io_stall), 32'd1);
    tick();
    chk("unhold_valid", 32'(io_ex_valid), 32'd0);
    chk("unhold_cnt", io_stall_count, 32'd2);

    // Asynchronous reset mid-operation
    instr(1'b1, 5'd1, 5'd2, 5'd3, 32'd11, 32'd22, 1'b0, 1'b1, 4'd0);
    tick();
    chk("pre_arst_valid", 32'(io_ex_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(io_ex_valid), 32'd0);
    chk("arst_d1", io_ex_rs1_data, 32'd0);
    chk("arst_cnt", io_stall_count, 32'd0);
    #1;
    reset = 1'b1;
    tick();
    chk("post_arst_d2", io_ex_rs2_data, 32'd22);

    // Counter saturation
    force dut.stall_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_count_q;
    instr(1'b1, 5'd2, 5'd0, 5'd4, 32'd0, 32'd0, 1'b1, 1'b1, 4'd0);
    tick();
    chk("sat_pre", io_stall_count, 32'hFFFF_FFFE);
    instr(1'b1, 5'd4, 5'd1, 5'd7, 32'd0, 32'd0, 1'b0, 1'b1, 4'd0);
    tick();
    chk("sat_top", io_stall_count, 32'hFFFF_FFFF);
    instr(1'b1, 5'd2, 5'd0, 5'd4, 32'd0, 32'd0, 1'b1, 1'b1, 4'd0);
    tick();
    instr(1'b1, 5'd4, 5'd1, 5'd7, 32'd0, 32'd0, 1'b0, 1'b1, 4'd0);
    #1;
    chk("sat_stall", 32'(io_stall), 32'd1);
    tick();
    chk("sat_hold", io_stall_count, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
